// File: rtl/tpu_pkg.sv
// tpu_pkg: shared requester ids, arbiter state type and defaults for the feature-map BRAM arbiter
package tpu_pkg;
  localparam int REQ_DMA = 0;
  localparam int REQ_CONV = 1;
  localparam int REQ_FC = 2;
  localparam int NUM_REQ_DEF = 3;
  typedef enum logic {S_IDLE, S_BURST} arb_state_e;
endpackage

// File: rtl/tpu_rr_pick.sv
// tpu_rr_pick: combinational round-robin picker, first requester after ptr wins
module tpu_rr_pick #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          any
);
  logic [PW-1:0] k;
  assign any = |req;
  // scan from furthest to nearest so the nearest requester after ptr overwrites the rest
  always_comb begin
    win = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (req[k]) begin
        win = '0;
        win[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tpu_bram_arb.sv
// tpu_bram_arb: burst-granularity round-robin sharing of one single-port feature-map BRAM
module tpu_bram_arb
  import tpu_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*LEN_W-1:0]  len_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic [NUM_REQ-1:0]        en_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic                      bram_en_o,
  output logic                      bram_we_o,
  output logic [ADDR_W-1:0]         bram_addr_o,
  output logic [DATA_W-1:0]         bram_wdata_o,
  input  logic [DATA_W-1:0]         bram_rdata_i,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int PW = $clog2(NUM_REQ);
  arb_state_e st, st_n;
  logic [LEN_W-1:0] cnt, cnt_n, wlen;
  logic [PW-1:0] ptr, ptr_n, widx;
  logic [NUM_REQ-1:0] gnt_n, win, pick_req, beat_v;
  logic any, beat, fin, arb;
  assign beat_v = gnt_o & en_i;
  assign beat = |beat_v;
  assign pick_req = (st == S_BURST) ? (req_i & ~gnt_o) : req_i;
  assign busy_o = (st == S_BURST);
  assign bram_en_o = beat;
  assign bram_we_o = |(beat_v & we_i);
  assign rdata_o = bram_rdata_i;
  tpu_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .win(win),
    .any(any)
  );
  // index and requested length of the picker's winner
  always_comb begin
    widx = '0;
    wlen = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) begin
        widx = PW'(i);
        wlen = len_i[i*LEN_W +: LEN_W];
      end
  end
  // port mux from the one-hot grant; an idle arbiter drives zeros
  always_comb begin
    bram_addr_o = '0;
    bram_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_o[i]) begin
        bram_addr_o = bram_addr_o | addr_i[i*ADDR_W +: ADDR_W];
        bram_wdata_o = bram_wdata_o | wdata_i[i*DATA_W +: DATA_W];
      end
  end
  // next state: arbitrate when idle or when the burst finishes (last beat or dropped request)
  always_comb begin
    fin = (st == S_BURST) && ((beat && cnt == LEN_W'(1)) || !(|(req_i & gnt_o)));
    arb = (st == S_IDLE) || fin;
    st_n = arb ? (any ? S_BURST : S_IDLE) : st;
    gnt_n = arb ? win : gnt_o;
    ptr_n = (arb && any) ? widx : ptr;
    cnt_n = arb ? ((wlen == '0) ? LEN_W'(1) : wlen) : (beat ? cnt - LEN_W'(1) : cnt);
  end
  // arbiter state, grant, beat counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      gnt_o <= '0;
      cnt <= '0;
      ptr <= PW'(NUM_REQ - 1);
    end else begin
      st <= st_n;
      gnt_o <= gnt_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
    end
  // read-valid follows the issuing grant one cycle later; err latches stray enables
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvalid_o <= '0;
      err_o <= 1'b0;
    end else begin
      rvalid_o <= beat_v & ~we_i;
      err_o <= err_o | (|(en_i & ~gnt_o));
    end
endmodule
